// File: rtl/mem_load_unit_pkg.sv
// ----------------------------------------------------------------------------
// mem_load_unit_pkg
// Purpose : shared types and constants for the memory load unit.
//           load_type encodings, FSM state enum, default timeout and the
//           wait-counter width.
// Ports   : none (package).
// ----------------------------------------------------------------------------
package mem_load_unit_pkg;

   localparam int unsigned TIMEOUT_CYCLES_DEF = 16;
   // TIMEOUT_CYCLES is at most 255, so the counter peaks at 255 on the exit cycle.
   localparam int unsigned CNT_W              = 8;
   localparam int unsigned DATA_W             = 32;

   typedef enum logic [1:0] {
      LT_LW  = 2'b00,
      LT_LH  = 2'b01,
      LT_LB  = 2'b10,
      LT_RSV = 2'b11   // reserved, handled as lw
   } load_type_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_REQ  = 2'b01,
      S_WAIT = 2'b10,
      S_DONE = 2'b11
   } state_e;

endpackage : mem_load_unit_pkg

// File: rtl/mem_load_unit_load_extract.sv
// ----------------------------------------------------------------------------
// load_extract
// Purpose : combinational lane select and sign extension of a memory word
//           for lw / lh / lb (little-endian byte lanes).
// Ports   : load_type_i  load size
//           byte_off_i   addr[1:0] of the load
//           rdata_i      raw memory word
//           result_o     extracted, sign-extended load value
// ----------------------------------------------------------------------------
module load_extract
   import mem_load_unit_pkg::*;
(
   input  load_type_e          load_type_i,
   input  logic [1:0]          byte_off_i,
   input  logic [DATA_W-1:0]   rdata_i,
   output logic [DATA_W-1:0]   result_o
);

   logic [15:0] half_c;
   logic [7:0]  byte_c;

   // Lane selection; lh only looks at the upper offset bit.
   always_comb begin
      half_c = byte_off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
      case (byte_off_i)
         2'd0:    byte_c = rdata_i[7:0];
         2'd1:    byte_c = rdata_i[15:8];
         2'd2:    byte_c = rdata_i[23:16];
         default: byte_c = rdata_i[31:24];
      endcase
   end

   // Sign extension per load size; reserved encoding behaves as lw.
   always_comb begin
      result_o = rdata_i;
      case (load_type_i)
         LT_LH:   result_o = {{16{half_c[15]}}, half_c};
         LT_LB:   result_o = {{24{byte_c[7]}}, byte_c};
         default: result_o = rdata_i;
      endcase
   end

endmodule : load_extract

// File: rtl/mem_load_unit.sv
// ----------------------------------------------------------------------------
// mem_load_unit
// Purpose : issues a single word read to memory, waits for mem_ready with a
//           bounded timeout, and returns the extracted load value in mdr.
// Params  : TIMEOUT_CYCLES  WAIT cycles before a read is abandoned (2..255)
// Macro   : LOAD_ALIGN_CHECK_EN  adds alignment checking and the misaligned
//           port; misaligned loads skip the memory read entirely.
// Ports   : clk, reset (async, active-high)
//           start, load_type, addr    load request (sampled in IDLE)
//           mem_rd, mem_addr          read strobe / word address
//           mem_rdata, mem_ready      read data / data-valid handshake
//           busy, done, timeout       status; done/timeout are 1-cycle pulses
//           mdr                       registered load result
//           misaligned                alignment fault pulse (macro only)
// ----------------------------------------------------------------------------
module mem_load_unit
   import mem_load_unit_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [1:0]        load_type,
   input  logic [DATA_W-1:0] addr,
   output logic              mem_rd,
   output logic [DATA_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready,
   output logic              busy,
   output logic              done,
   output logic              timeout,
   output logic [DATA_W-1:0] mdr
`ifdef LOAD_ALIGN_CHECK_EN
   ,
   output logic              misaligned
`endif
);

   state_e              state_q,    state_d;
   load_type_e          lt_q,       lt_d;
   logic [DATA_W-1:0]   addr_q,     addr_d;
   logic [CNT_W-1:0]    cnt_q,      cnt_d;
   logic [DATA_W-1:0]   mdr_q,      mdr_d;
   logic [DATA_W-1:0]   mem_addr_q, mem_addr_d;
   logic                mem_rd_q,   mem_rd_d;
   logic                busy_q,     busy_d;
   logic                done_q,     done_d;
   logic                timeout_q,  timeout_d;
   logic [DATA_W-1:0]   extract_c;
`ifdef LOAD_ALIGN_CHECK_EN
   logic                misal_q,    misal_d;
   logic                align_fault_c;
`endif

   load_extract u_extract (
      .load_type_i (lt_q),
      .byte_off_i  (addr_q[1:0]),
      .rdata_i     (mem_rdata),
      .result_o    (extract_c)
   );

`ifdef LOAD_ALIGN_CHECK_EN
   // Fault check uses the live request inputs since it decides the IDLE exit.
   always_comb begin
      case (load_type_e'(load_type))
         LT_LH:   align_fault_c = addr[0];
         LT_LB:   align_fault_c = 1'b0;
         default: align_fault_c = (addr[1:0] != 2'b00);
      endcase
   end
`endif

   // Next-state logic; registered outputs are derived from the next state so
   // they line up with the state they describe.
   always_comb begin
      state_d   = state_q;
      lt_d      = lt_q;
      addr_d    = addr_q;
      cnt_d     = cnt_q;
      mdr_d     = mdr_q;
      timeout_d = 1'b0;
`ifdef LOAD_ALIGN_CHECK_EN
      misal_d   = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               lt_d    = load_type_e'(load_type);
               addr_d  = addr;
               state_d = S_REQ;
`ifdef LOAD_ALIGN_CHECK_EN
               if (align_fault_c) begin
                  state_d = S_DONE;
                  misal_d = 1'b1;
               end
`endif
            end
         end
         S_REQ: begin
            cnt_d   = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            cnt_d = cnt_q + CNT_W'(1);
            // Data arriving on the last allowed cycle takes priority over timeout.
            if (mem_ready) begin
               mdr_d   = extract_c;
               state_d = S_DONE;
            end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               timeout_d = 1'b1;
               state_d   = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      mem_rd_d   = (state_d == S_REQ);
      busy_d     = (state_d != S_IDLE);
      done_d     = (state_d == S_DONE);
      mem_addr_d = (state_d == S_IDLE) ? '0 : {addr_d[DATA_W-1:2], 2'b00};
   end

   // State and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         lt_q       <= LT_LW;
         addr_q     <= '0;
         cnt_q      <= '0;
         mdr_q      <= '0;
         mem_addr_q <= '0;
         mem_rd_q   <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         timeout_q  <= 1'b0;
`ifdef LOAD_ALIGN_CHECK_EN
         misal_q    <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         lt_q       <= lt_d;
         addr_q     <= addr_d;
         cnt_q      <= cnt_d;
         mdr_q      <= mdr_d;
         mem_addr_q <= mem_addr_d;
         mem_rd_q   <= mem_rd_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         timeout_q  <= timeout_d;
`ifdef LOAD_ALIGN_CHECK_EN
         misal_q    <= misal_d;
`endif
      end
   end

   assign mem_rd   = mem_rd_q;
   assign mem_addr = mem_addr_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign timeout  = timeout_q;
   assign mdr      = mdr_q;
`ifdef LOAD_ALIGN_CHECK_EN
   assign misaligned = misal_q;
`endif

endmodule : mem_load_unit
